// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: enable, settle, then count synchronized ro_in edges over a clk gate.
// Optional threshold comparator (thresh / below_thresh) is built when RO_FREQ_CMP_EN is defined.
module ro_freq_counter #(
  parameter int GATE_CYCLES   = 1024,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ro_in,
`ifdef RO_FREQ_CMP_EN
  input  logic [CNT_W-1:0] thresh,
  output logic             below_thresh,
`endif
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [GW-1:0] GATE_LAST   = GW'(GATE_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_GATE   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]             state_r, state_nx_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_prev_r;
  logic                   edge_s;
  logic [SW-1:0]          settle_cnt_r;
  logic [GW-1:0]          gate_cnt_r;
  logic                   settle_last_s, gate_last_s, gate_entry_s;
  logic [CNT_W-1:0]       count_r, count_nx_s;
  logic                   overflow_r, overflow_nx_s;
  logic                   ro_en_r, busy_r, done_r;

  assign edge_s        = sync_r[SYNC_STAGES-1] & ~sync_prev_r;
  assign settle_last_s = (state_r == ST_SETTLE) && (settle_cnt_r == SETTLE_LAST);
  assign gate_last_s   = (state_r == ST_GATE) && (gate_cnt_r == GATE_LAST);
  assign gate_entry_s  = settle_last_s;

  // Next-state decode; start is only honoured from IDLE or DONE.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE:   if (start) state_nx_s = ST_SETTLE; else state_nx_s = ST_IDLE;
      ST_SETTLE: if (settle_last_s) state_nx_s = ST_GATE; else state_nx_s = ST_SETTLE;
      ST_GATE:   if (gate_last_s) state_nx_s = ST_DONE; else state_nx_s = ST_GATE;
      ST_DONE:   if (start) state_nx_s = ST_SETTLE; else state_nx_s = ST_IDLE;
      default:   state_nx_s = ST_IDLE;
    endcase
  end

  // Saturating edge counter: cleared on gate entry, held outside the gate.
  always_comb begin
    count_nx_s    = count_r;
    overflow_nx_s = overflow_r;
    if (gate_entry_s) begin
      count_nx_s    = {CNT_W{1'b0}};
      overflow_nx_s = 1'b0;
    end else if ((state_r == ST_GATE) && edge_s) begin
      if (count_r == {CNT_W{1'b1}}) begin
        overflow_nx_s = 1'b1;
      end else begin
        count_nx_s = count_r + CNT_W'(1);
      end
    end else begin
      count_nx_s    = count_r;
      overflow_nx_s = overflow_r;
    end
  end

  // Synchronizer and edge history run in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r      <= {SYNC_STAGES{1'b0}};
      sync_prev_r <= 1'b0;
    end else begin
      sync_r      <= {sync_r[SYNC_STAGES-2:0], ro_in};
      sync_prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // FSM, window counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      settle_cnt_r <= {SW{1'b0}};
      gate_cnt_r   <= {GW{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      overflow_r   <= 1'b0;
      ro_en_r      <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      settle_cnt_r <= ((state_r == ST_SETTLE) && !settle_last_s) ? settle_cnt_r + SW'(1) : {SW{1'b0}};
      gate_cnt_r   <= ((state_r == ST_GATE) && !gate_last_s) ? gate_cnt_r + GW'(1) : {GW{1'b0}};
      count_r      <= count_nx_s;
      overflow_r   <= overflow_nx_s;
      ro_en_r      <= (state_nx_s == ST_SETTLE) || (state_nx_s == ST_GATE);
      busy_r       <= (state_nx_s == ST_SETTLE) || (state_nx_s == ST_GATE);
      done_r       <= (state_nx_s == ST_DONE);
    end
  end

  assign ro_en    = ro_en_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign count    = count_r;
  assign overflow = overflow_r;

`ifdef RO_FREQ_CMP_EN
  logic [CNT_W-1:0] thresh_r;
  logic             below_r;

  // Threshold captured at gate entry; verdict uses the final count and lands with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thresh_r <= {CNT_W{1'b0}};
      below_r  <= 1'b0;
    end else begin
      if (gate_entry_s) thresh_r <= thresh;
      else              thresh_r <= thresh_r;
      if (gate_last_s) below_r <= !overflow_nx_s && (count_nx_s < thresh_r);
      else             below_r <= below_r;
    end
  end

  assign below_thresh = below_r;
`endif

endmodule

// File: tb/tb_ro_freq_counter.sv
// Directed bench for ro_freq_counter (SETTLE=4, GATE=16); comparator checks when RO_FREQ_CMP_EN is defined.
module tb_ro_freq_counter;
  logic        clk = 1'b0;
  logic        rst_n, start, start3, ro_in;
  logic        ro_en, busy, done, overflow;
  logic [15:0] count;
  logic        ro_en3, busy3, done3, overflow3;
  logic [2:0]  count3;
`ifdef RO_FREQ_CMP_EN
  logic [15:0] thresh;
  logic        below_thresh;
  logic [2:0]  thresh3;
  logic        below3;
`endif
  int n_tests = 0;
  int n_fail  = 0;
  int mode    = 0;
  int phase   = 0;

  ro_freq_counter #(.GATE_CYCLES(16), .SETTLE_CYCLES(4), .CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ro_in(ro_in),
`ifdef RO_FREQ_CMP_EN
    .thresh(thresh), .below_thresh(below_thresh),
`endif
    .ro_en(ro_en), .busy(busy), .done(done), .count(count), .overflow(overflow));

  ro_freq_counter #(.GATE_CYCLES(16), .SETTLE_CYCLES(4), .CNT_W(3), .SYNC_STAGES(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .ro_in(ro_in),
`ifdef RO_FREQ_CMP_EN
    .thresh(thresh3), .below_thresh(below3),
`endif
    .ro_en(ro_en3), .busy(busy3), .done(done3), .count(count3), .overflow(overflow3));

  always #5 clk = ~clk;

  // Oscillator model: 0 low, 1 high, 2 period 4 clk, 3 period 2 clk.
  initial begin
    ro_in = 1'b0;
    forever begin
      @(negedge clk);
      phase++;
      case (mode)
        1:       ro_in = 1'b1;
        2:       ro_in = phase[1];
        3:       ro_in = phase[0];
        default: ro_in = 1'b0;
      endcase
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic measure(output int lat);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      if (done === 1'b1) begin lat = c; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle(3);
    n_tests++; if (ro_en !== 1'b0)  begin n_fail++; $display("FAIL reset_ro_en: got %b want 0", ro_en); end
    n_tests++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (done !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_tests++; if (count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    @(negedge clk); rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic;
    mode = 2;
    idle(6);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      n_tests++;
      if (ro_en !== (c <= 20)) begin n_fail++; $display("FAIL basic_ro_en c=%0d: got %b want %b", c, ro_en, (c <= 20)); end
      n_tests++;
      if (done !== (c == 21)) begin n_fail++; $display("FAIL basic_done c=%0d: got %b want %b", c, done, (c == 21)); end
      if (c == 21) begin
        n_tests++; if (count !== 16'd4) begin n_fail++; $display("FAIL basic_count: got %0d want 4", count); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL basic_overflow: got %b want 0", overflow); end
      end
      @(posedge clk); #1;
    end
    idle(3);
    n_tests++; if (count !== 16'd4) begin n_fail++; $display("FAIL basic_count_hold: got %0d want 4", count); end
  endtask

  task automatic test_hold;
    int lat;
    for (int m = 1; m >= 0; m--) begin
      mode = m;
      idle(6);
      measure(lat);
      n_tests++; if (lat !== 21) begin n_fail++; $display("FAIL hold%0d_latency: got %0d want 21", m, lat); end
      n_tests++; if (count !== 16'd0) begin n_fail++; $display("FAIL hold%0d_count: got %0d want 0", m, count); end
      n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL hold%0d_overflow: got %b want 0", m, overflow); end
      idle(2);
    end
  endtask

  task automatic test_saturate;
    int lat;
    mode = 3;
    idle(6);
    @(posedge clk); #1 start3 = 1'b1;
    @(posedge clk); #1 start3 = 1'b0;
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      if (done3 === 1'b1) begin lat = c; break; end
      @(posedge clk); #1;
    end
    n_tests++; if (lat !== 21) begin n_fail++; $display("FAIL sat_latency: got %0d want 21", lat); end
    n_tests++; if (count3 !== 3'd7) begin n_fail++; $display("FAIL sat_count: got %0d want 7", count3); end
    n_tests++; if (overflow3 !== 1'b1) begin n_fail++; $display("FAIL sat_overflow: got %b want 1", overflow3); end
`ifdef RO_FREQ_CMP_EN
    n_tests++; if (below3 !== 1'b0) begin n_fail++; $display("FAIL sat_below: got %b want 0", below3); end
`endif
    idle(2);
  endtask

  task automatic test_back_to_back;
    int lat;
    int dones;
    mode = 2;
    idle(4);
    dones = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 21; c++) begin
      if (c == 21) start = 1'b0;
      if (done === 1'b1) dones++;
      if (c <= 20) begin
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy c=%0d: got %b want 1", c, busy); end
      end
      @(posedge clk); #1;
    end
    n_tests++; if (dones !== 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 1", dones); end
    idle(1);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_not_queued: got %b want 0", busy); end
    measure(lat);
    n_tests++; if (count !== 16'd4) begin n_fail++; $display("FAIL b2b_first_count: got %0d want 4", count); end
    mode = 0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_busy: got %b want 1", busy); end
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 4) begin
        n_tests++; if (count !== 16'd4) begin n_fail++; $display("FAIL b2b_count_held: got %0d want 4", count); end
      end
      if (done === 1'b1) begin lat = c; break; end
      @(posedge clk); #1;
    end
    n_tests++; if (lat !== 21) begin n_fail++; $display("FAIL b2b_restart_latency: got %0d want 21", lat); end
    n_tests++; if (count !== 16'd0) begin n_fail++; $display("FAIL b2b_second_count: got %0d want 0", count); end
    idle(2);
  endtask

  task automatic test_reset_mid;
    int dones;
    mode = 2;
    idle(4);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    idle(12);
    n_tests++; if (count !== 16'd2) begin n_fail++; $display("FAIL mid_partial_count: got %0d want 2", count); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (ro_en !== 1'b0) begin n_fail++; $display("FAIL mid_ro_en: got %b want 0", ro_en); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_tests++; if (count !== 16'd0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", count); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_done: got %b want 0", done); end
    idle(2);
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    n_tests++; if (dones !== 0) begin n_fail++; $display("FAIL mid_no_done: got %0d active cycles want 0", dones); end
  endtask

`ifdef RO_FREQ_CMP_EN
  task automatic test_cmp;
    int lat;
    mode = 2;
    thresh = 16'd5;
    measure(lat);
    n_tests++; if (below_thresh !== 1'b1) begin n_fail++; $display("FAIL cmp_t5: got %b want 1", below_thresh); end
    idle(3);
    n_tests++; if (below_thresh !== 1'b1) begin n_fail++; $display("FAIL cmp_hold: got %b want 1", below_thresh); end
    thresh = 16'd4;
    measure(lat);
    n_tests++; if (below_thresh !== 1'b0) begin n_fail++; $display("FAIL cmp_t4: got %b want 0", below_thresh); end
    idle(2);
    thresh = 16'd5;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    idle(8);
    thresh = 16'd0;
    lat = 0;
    for (int c = 9; c <= 60; c++) begin
      if (done === 1'b1) begin lat = c; break; end
      @(posedge clk); #1;
    end
    n_tests++; if (below_thresh !== 1'b1) begin n_fail++; $display("FAIL cmp_sampled: got %b want 1", below_thresh); end
    idle(2);
  endtask
`endif

  initial begin
    start  = 1'b0;
    start3 = 1'b0;
`ifdef RO_FREQ_CMP_EN
    thresh  = 16'd0;
    thresh3 = 3'd7;
`endif
    test_reset();
    test_basic();
    test_hold();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
`ifdef RO_FREQ_CMP_EN
    test_cmp();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
